// File: rtl/swdb_pkg.sv
// Shared defaults and a sizing helper for the switch debouncer.
package swdb_pkg;

   localparam int SWDB_WIDTH        = 8;
   localparam int SWDB_TICK_DIV     = 50000;
   localparam int SWDB_STABLE_TICKS = 10;

   function automatic int swdb_clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/swdb_bit.sv
// One debounced switch bit: two-flop synchronizer, tick-driven
// disagreement counter and the accepted (stable) level.
module swdb_bit
   import swdb_pkg::*;
#(
   parameter int STABLE_TICKS = SWDB_STABLE_TICKS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic raw,
   output logic stable
);

   localparam int CW = swdb_clog2(STABLE_TICKS + 1);
   localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Any sample that agrees with the stable level restarts the count, so a
   // bounce back costs the whole interval again.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (tick) begin
            if (cnt == LAST) begin
               stable <= sync2;
               cnt    <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/switch_debounce.sv
// Debounces a bank of slide switches and flags settled changes.
// Define SWDB_ONEHOT_EN to present only the lowest set debounced bit.
module switch_debounce
   import swdb_pkg::*;
#(
   parameter int WIDTH        = SWDB_WIDTH,
   parameter int TICK_DIV     = SWDB_TICK_DIV,
   parameter int STABLE_TICKS = SWDB_STABLE_TICKS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_stable,
   output logic             sw_changed,
   output logic [WIDTH-1:0] changed_mask
);

   localparam int PW = (TICK_DIV > 1) ? swdb_clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0]    pre;
   logic             tick;
   logic [WIDTH-1:0] debounced;
   logic [WIDTH-1:0] view;
   logic [WIDTH-1:0] view_prev;

   assign tick = (pre == PRE_LAST);

   // Free-running prescaler shared by every bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= '0;
      end else if (tick) begin
         pre <= '0;
      end else begin
         pre <= pre + PW'(1);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      swdb_bit #(
         .STABLE_TICKS(STABLE_TICKS)
      ) u_bit (
         .clk   (clk),
         .rst_n (rst_n),
         .tick  (tick),
         .raw   (sw_raw[i]),
         .stable(debounced[i])
      );
   end

`ifdef SWDB_ONEHOT_EN
   assign view = debounced & (~debounced + WIDTH'(1));
`else
   assign view = debounced;
`endif

   // Change detection compares the presented vector against its value one
   // cycle earlier, so the strobe lands in the same cycle as the new value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         view_prev <= '0;
      end else begin
         view_prev <= view;
      end
   end

   assign sw_stable    = view;
   assign changed_mask = view ^ view_prev;
   assign sw_changed   = |changed_mask;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed self-checking bench for switch_debounce (TICK_DIV=4, STABLE_TICKS=3).
module tb_switch_debounce;

   logic       clk;
   logic       rst_n;
   logic [7:0] sw_raw;
   logic [7:0] sw_stable;
   logic       sw_changed;
   logic [7:0] changed_mask;

   int checks;
   int errors;

   switch_debounce #(
      .WIDTH       (8),
      .TICK_DIV    (4),
      .STABLE_TICKS(3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sw_raw      (sw_raw),
      .sw_stable   (sw_stable),
      .sw_changed  (sw_changed),
      .changed_mask(changed_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] value);
      @(negedge clk);
      sw_raw = value;
   endtask

   // Counts negedges after the stimulus until sw_changed; -1 on timeout.
   task automatic waitChange(input int maxCycles, output int lat);
      lat = -1;
      for (int n = 1; n <= maxCycles; n++) begin
         @(negedge clk);
         if (sw_changed) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic checkPulseEnds(input string tag);
      @(negedge clk);
      checkOutput({tag, "_pulse_end"}, {31'd0, sw_changed}, 32'd0);
      checkOutput({tag, "_mask_clear"}, {24'd0, changed_mask}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      int pulses;

      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      sw_raw = 8'h00;
      repeat (3) @(negedge clk);
      checkOutput("reset_stable", {24'd0, sw_stable}, 32'd0);
      checkOutput("reset_changed", {31'd0, sw_changed}, 32'd0);
      checkOutput("reset_mask", {24'd0, changed_mask}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

`ifdef SWDB_ONEHOT_EN
      applyStimulus(8'h0C);
      waitChange(20, lat);
      checkOutput("oh_first_lat", {31'd0, (lat >= 11 && lat <= 14)}, 32'd1);
      checkOutput("oh_first_stable", {24'd0, sw_stable}, 32'h04);
      checkOutput("oh_first_mask", {24'd0, changed_mask}, 32'h04);
      checkPulseEnds("oh_first");

      applyStimulus(8'h08);
      waitChange(20, lat);
      checkOutput("oh_second_lat", {31'd0, (lat >= 11 && lat <= 14)}, 32'd1);
      checkOutput("oh_second_stable", {24'd0, sw_stable}, 32'h08);
      checkOutput("oh_second_mask", {24'd0, changed_mask}, 32'h0C);
      checkPulseEnds("oh_second");
`else
      // Clean edge on bit 2
      applyStimulus(8'h04);
      waitChange(20, lat);
      checkOutput("clean_lat", {31'd0, (lat >= 11 && lat <= 14)}, 32'd1);
      checkOutput("clean_stable", {24'd0, sw_stable}, 32'h04);
      checkOutput("clean_mask", {24'd0, changed_mask}, 32'h04);
      checkPulseEnds("clean");

      // Bit 0 bounces every 5 cycles: never stable for three ticks
      pulses = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if ((i % 5) == 0) sw_raw[0] = ((i / 5) % 2) == 0;
         if (sw_changed) pulses++;
      end
      checkOutput("bounce_pulses", pulses, 32'd0);
      checkOutput("bounce_stable", {24'd0, sw_stable}, 32'h04);
      applyStimulus(8'h05);
      waitChange(14, lat);
      checkOutput("bounce_settle_seen", {31'd0, (lat >= 1)}, 32'd1);
      checkOutput("bounce_mask", {24'd0, changed_mask}, 32'h01);
      checkOutput("bounce_stable_final", {24'd0, sw_stable}, 32'h05);
      checkPulseEnds("bounce");

      applyStimulus(8'h00);
      waitChange(20, lat);
      checkOutput("clear_mask", {24'd0, changed_mask}, 32'h05);
      checkOutput("clear_stable", {24'd0, sw_stable}, 32'h00);

      // Two bits accepted on the same tick
      applyStimulus(8'h81);
      waitChange(20, lat);
      checkOutput("simul_lat", {31'd0, (lat >= 11 && lat <= 14)}, 32'd1);
      checkOutput("simul_mask", {24'd0, changed_mask}, 32'h81);
      checkOutput("simul_stable", {24'd0, sw_stable}, 32'h81);
      checkPulseEnds("simul");

      applyStimulus(8'h01);
      waitChange(20, lat);
      checkOutput("release_lat", {31'd0, (lat >= 11 && lat <= 14)}, 32'd1);
      checkOutput("release_mask", {24'd0, changed_mask}, 32'h80);
      checkOutput("release_stable", {24'd0, sw_stable}, 32'h01);
      checkPulseEnds("release");

      applyStimulus(8'h00);
      waitChange(20, lat);
      checkOutput("prep_mask", {24'd0, changed_mask}, 32'h01);

      // Reset partway through debouncing bit 3
      applyStimulus(8'h08);
      pulses = 0;
      repeat (8) begin
         @(negedge clk);
         if (sw_changed) pulses++;
      end
      checkOutput("rst_early_pulses", pulses, 32'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_stable", {24'd0, sw_stable}, 32'd0);
      checkOutput("rst_mid_changed", {31'd0, sw_changed}, 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("rst_hold_stable", {24'd0, sw_stable}, 32'd0);
      checkOutput("rst_hold_mask", {24'd0, changed_mask}, 32'd0);
      rst_n = 1'b1;
      waitChange(20, lat);
      checkOutput("rst_after_lat", {31'd0, (lat >= 11 && lat <= 14)}, 32'd1);
      checkOutput("rst_after_stable", {24'd0, sw_stable}, 32'h08);
      checkOutput("rst_after_mask", {24'd0, changed_mask}, 32'h08);
      checkPulseEnds("rst_after");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Front-end conditioning stage for the slide-switch bank.
- Synchronizes and debounces WIDTH raw switch inputs, then presents a clean, glitch-free bus to the downstream switch-to-binary priority encoder.
- Emits a one-cycle change strobe and per-bit change mask so consumers can react to settled edits without polling.

Parameters:
- WIDTH, 8, number of switch inputs.
- TICK_DIV, 50000, clock cycles per sample tick (1 ms at 50 MHz); legal range >= 1.
- STABLE_TICKS, 10, consecutive ticks an input must disagree with the stable value before it is accepted; legal range >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sw_raw  in  WIDTH  raw, asynchronous switch levels.
- sw_stable  out  WIDTH  debounced switch levels; feeds the priority encoder's sw input.
- sw_changed  out  1  one-cycle pulse when any bit of sw_stable changes.
- changed_mask  out  WIDTH  bits of sw_stable that changed this cycle; all zero when sw_changed is 0.

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on rst_n. While rst_n=0, all registers are 0: synchronizer flops, prescaler, per-bit counters, sw_stable=0, sw_changed=0, changed_mask=0. Reset mid-debounce discards progress. Switches held on through reset reappear only after a full debounce interval.
- Synchronizer: 2 flops per bit (sync1 to sync2). Only sync2 is used downstream.
- Prescaler: counter 0..TICK_DIV-1. tick=1 when count==TICK_DIV-1, then wraps to 0. With TICK_DIV=1, tick=1 every cycle. The prescaler is shared by all bits and free-running.
- Per-bit counter cnt[i], width clog2(STABLE_TICKS+1):
  - If sync2[i]==sw_stable[i]: cnt[i] <= 0 on every clock, independent of tick. A bounce back therefore restarts the count.
  - Else, on tick: if cnt[i]==STABLE_TICKS-1, then sw_stable[i] <= sync2[i] and cnt[i] <= 0; otherwise cnt[i]++.
  - Else, no tick: hold.
- Latency from a clean sw_raw edge to the sw_stable update: 2 + (STABLE_TICKS-1)*TICK_DIV + 1 up to 2 + STABLE_TICKS*TICK_DIV cycles, depending on prescaler phase.
- sw_changed and changed_mask are registered together with sw_stable, so they are valid in the same cycle the new sw_stable value appears.
  - Pulse width is exactly 1 cycle.
  - Simultaneous acceptance of several bits on one tick produces a single pulse with multiple mask bits set.
- Bits are fully independent. Several bits may be mid-count at once.
- No backpressure: consumers must sample the strobe on the cycle it is asserted.

Optional Feature:
- Macro: SWDB_ONEHOT_EN.
- Defined:
  - sw_stable presents only the lowest-index set bit of the internal debounced vector (isolate-lowest-one); all other bits read 0. Gives the downstream encoder a strictly one-hot or zero input.
  - changed_mask and sw_changed are computed on this filtered vector. A change to a masked higher bit produces no strobe.
  - The internal debounced state is unaffected.
- Undefined: sw_stable is the raw debounced vector.
- Port list is identical in both builds.

Decomposition:
- Package swdb_pkg: default constants SWDB_WIDTH=8, SWDB_TICK_DIV=50000, SWDB_STABLE_TICKS=10, and a clog2 constant function for counter sizing.
- Sub-module swdb_bit: 2-flop synchronizer, counter and stable flop for one bit; inputs clk, rst_n, tick, raw; output stable.
  - The top level generates WIDTH instances, owns the prescaler, and forms the change logic (stable vs. previous-stable XOR) and the optional one-hot filter.

Test Plan:
All scenarios use TICK_DIV=4, STABLE_TICKS=3.
- Clean edge: sw_raw 0x00->0x04 held. sw_stable=0x04 between 11 and 14 cycles later; sw_changed=1 for 1 cycle with changed_mask=0x04.
- Bounce: toggle bit 0 every 5 cycles for 60 cycles, then hold 1. No sw_changed during the bounce; one pulse with mask 0x01 within 14 cycles of the final hold.
- Simultaneous: sw_raw 0x00->0x81 in one cycle. A single sw_changed pulse with changed_mask=0x81; sw_stable=0x81.
- Release: from stable 0x81, sw_raw->0x01. After debounce, sw_stable=0x01 and changed_mask=0x80.
- Reset mid-debounce: raise bit 3, assert rst_n=0 eight cycles later for 3 cycles, then release with bit 3 still high. Outputs are 0 during reset, and sw_stable=0x08 only 11-14 cycles after reset release.
- SWDB_ONEHOT_EN build: sw_raw 0x00->0x0C gives sw_stable=0x04; then sw_raw->0x08 gives sw_stable=0x08, changed_mask=0x0C.
